// File: rtl/trng_ram_reader.sv
// trng_ram_reader
// Read-back engine for the 1-bit-wide TRNG capture RAM. On start it walks
// RAM addresses 0..DEPTH-1, packs the bits LSB-first into bytes and hands
// them to a valid/ready byte stream toward the host link.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start             one-cycle pulse, begins a dump (ignored unless idle)
//   ram_addr          registered RAM read address
//   ram_q             RAM read data, valid RD_LAT cycles after address edge
//   dout/dout_valid   packed byte stream, bit k = RAM[8n+k]
//   dout_ready        sink accepts byte
//   busy              dump in progress
//   done              one-cycle pulse after the last byte is accepted
//   ones_cnt          (only with TRNG_ONES_CNT_EN) count of 1 bits read
//
// Optional feature macro: TRNG_ONES_CNT_EN adds the ones_cnt output.
module trng_ram_reader #(
  parameter int DEPTH  = 100000,
  parameter int ADDR_W = 17,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic              ram_q,
  output logic [7:0]        dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              busy,
  output logic              done
`ifdef TRNG_ONES_CNT_EN
  ,
  output logic [ADDR_W-1:0] ones_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WAIT, S_CAPT, S_SEND, S_FIN
  } state_t;

  // idx needs one extra bit so it can hold DEPTH itself after the last bit
  localparam logic [ADDR_W:0] LAST_IDX  = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] END_IDX   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] IDX_ONE   = (ADDR_W+1)'(1);
  localparam logic [1:0]      WAIT_LAST = 2'(RD_LAT - 2);

  state_t            state, state_nxt;
  logic [ADDR_W:0]   idx, idx_nxt;
  logic [7:0]        shreg;
  logic [1:0]        wait_cnt;
  logic              last_bit;

  // byte closes on bit 7 of a byte or on the final RAM entry
  assign last_bit = (idx[2:0] == 3'd7) || (idx == LAST_IDX);

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // next-state and next-index logic
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      S_IDLE: if (start) begin
        state_nxt = S_ADDR;
        idx_nxt   = '0;
      end
      S_ADDR: state_nxt = (RD_LAT == 1) ? S_CAPT : S_WAIT;
      S_WAIT: if (wait_cnt == WAIT_LAST) state_nxt = S_CAPT;
      S_CAPT: begin
        state_nxt = last_bit ? S_SEND : S_ADDR;
        idx_nxt   = idx + IDX_ONE;
      end
      S_SEND: if (dout_ready) state_nxt = (idx == END_IDX) ? S_FIN : S_ADDR;
      S_FIN:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      shreg    <= '0;
      wait_cnt <= '0;
      ram_addr <= '0;
    end else begin
      idx <= idx_nxt;
      // address is loaded on entry to ADDR so the RAM sees it for that cycle
      if (state_nxt == S_ADDR) ram_addr <= idx_nxt[ADDR_W-1:0];
      wait_cnt <= (state == S_WAIT) ? wait_cnt + 2'd1 : 2'd0;
      if (state == S_CAPT) shreg[idx[2:0]] <= ram_q;
      // cleared after hand-off so a partial last byte pads with zeros
      if (state == S_SEND && dout_ready) shreg <= '0;
    end
  end

`ifdef TRNG_ONES_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)                                ones_cnt <= '0;
    else if (state == S_IDLE && start)      ones_cnt <= '0;
    else if (state == S_CAPT && ram_q)      ones_cnt <= ones_cnt + ADDR_W'(1);
  end
`endif

  // outputs
  always_comb begin
    busy       = (state == S_ADDR) || (state == S_WAIT) ||
                 (state == S_CAPT) || (state == S_SEND);
    done       = (state == S_FIN);
    dout_valid = (state == S_SEND);
    dout       = dout_valid ? shreg : 8'h00;
  end

endmodule
